// File: rtl/pucch_bpsk_pkg.sv
// Shared PUCCH BPSK definitions: constellation points on the cyclic phase
// grid (also used by the transmit mapper), circular distance, metric width
// helper and the demodulator state enum.
package pucch_bpsk_pkg;

    typedef enum logic {
        ACC  = 1'b0,
        DONE = 1'b1
    } state_t;

    // Phase index carrying bit 0.
    function automatic int unsigned bpsk_p0(input int unsigned cyc_div);
        return cyc_div / 4 - cyc_div / 8;
    endfunction

    // Phase index carrying bit 1.
    function automatic int unsigned bpsk_p1(input int unsigned cyc_div);
        return (3 * cyc_div) / 4 - cyc_div / 8;
    endfunction

    // Shortest distance between two points on a ring of cyc_div positions.
    // Both x and p are expected to lie in 0..cyc_div-1.
    function automatic int unsigned circ_dist(input int unsigned x,
                                              input int unsigned p,
                                              input int unsigned cyc_div);
        int unsigned diff;
        diff = (x > p) ? (x - p) : (p - x);
        return (diff <= cyc_div - diff) ? diff : (cyc_div - diff);
    endfunction

    // Signed width able to hold +/- cyc_div/2.
    function automatic int unsigned metric_width(input int unsigned cyc_div);
        return $clog2(cyc_div / 2 + 1) + 1;
    endfunction

endpackage

// File: rtl/bpsk_cyc_demod_phase_metric.sv
// bpsk_phase_metric: combinational per-symbol soft metric.
//   i_cyc_part  : received phase index
//   o_metric    : d(x,P1) - d(x,P0), positive favours bit 0; zero when out of range
//   o_range_err : index is >= CYC_DIV
module bpsk_phase_metric
    import pucch_bpsk_pkg::*;
#(
    parameter int unsigned CYC_DIV = 24,
    parameter int unsigned M_W     = metric_width(24)
) (
    input  logic [4:0]            i_cyc_part,
    output logic signed [M_W-1:0] o_metric,
    output logic                  o_range_err
);

    localparam int unsigned P0 = bpsk_p0(CYC_DIV);
    localparam int unsigned P1 = bpsk_p1(CYC_DIV);

    logic [31:0] w_d0;
    logic [31:0] w_d1;

    always_comb begin
        o_range_err = ({27'd0, i_cyc_part} >= CYC_DIV);
        w_d0        = circ_dist({27'd0, i_cyc_part}, P0, CYC_DIV);
        w_d1        = circ_dist({27'd0, i_cyc_part}, P1, CYC_DIV);
        // Two's-complement difference truncated to the metric width; the
        // true value is bounded by +/- CYC_DIV/2 so no information is lost.
        o_metric    = o_range_err ? '0 : M_W'(w_d1 - w_d0);
    end

endmodule

// File: rtl/bpsk_cyc_demod.sv
// bpsk_cyc_demod: BPSK demapper combining N_SYM cyclic phase indices into one
// signed soft metric and a hard bit decision per block.
//   i_clk, i_rst     : clock, asynchronous active-high reset
//   i_flush          : synchronous block abort (priority over all else)
//   i_valid/o_ready  : phase input handshake, i_cyc_part = phase index
//   o_valid/i_ready  : decision output handshake
//   o_bit            : hard decision (sum<0 -> 1)
//   o_sum            : signed combined metric
//   o_erasure        : combined metric was exactly zero
//   o_range_err      : some index in the block was >= CYC_DIV
module bpsk_cyc_demod
    import pucch_bpsk_pkg::*;
#(
    parameter int unsigned CYC_DIV = 24,
    parameter int unsigned N_SYM   = 7,
    parameter int unsigned ACC_W   = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_valid,
    input  logic [4:0]       i_cyc_part,
    output logic             o_ready,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_bit,
    output logic [ACC_W-1:0] o_sum,
    output logic             o_erasure,
    output logic             o_range_err
);

    localparam int unsigned M_W   = metric_width(CYC_DIV);
    localparam int unsigned CNT_W = $clog2(N_SYM + 1);

    state_t r_state;
    state_t w_state_nxt;

    logic signed [M_W-1:0]   w_metric;
    logic                    w_sym_rerr;
    logic signed [ACC_W-1:0] w_acc_add;
    logic                    w_accept;
    logic                    w_release;
    logic                    w_last;

    logic signed [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_rerr_sticky;
    logic                    r_bit;
    logic signed [ACC_W-1:0] r_sum;
    logic                    r_erasure;
    logic                    r_range_err;

    bpsk_phase_metric #(
        .CYC_DIV (CYC_DIV),
        .M_W     (M_W)
    ) u_metric (
        .i_cyc_part  (i_cyc_part),
        .o_metric    (w_metric),
        .o_range_err (w_sym_rerr)
    );

    // Signed size cast sign-extends the metric to the accumulator width.
    assign w_acc_add = r_acc + ACC_W'(w_metric);
    assign w_last    = (r_cnt == CNT_W'(N_SYM - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ACC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_ready     = 1'b0;
        o_valid     = 1'b0;
        w_accept    = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            ACC: begin
                o_ready  = 1'b1;
                w_accept = i_valid && !i_flush;
                if (w_accept && w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                o_valid   = 1'b1;
                w_release = i_ready && !i_flush;
                if (w_release) begin
                    w_state_nxt = ACC;
                end
            end
        endcase
        if (i_flush) begin
            w_state_nxt = ACC;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_acc         <= '0;
            r_cnt         <= '0;
            r_rerr_sticky <= 1'b0;
            r_bit         <= 1'b0;
            r_sum         <= '0;
            r_erasure     <= 1'b0;
            r_range_err   <= 1'b0;
        end else if (i_flush) begin
            r_acc         <= '0;
            r_cnt         <= '0;
            r_rerr_sticky <= 1'b0;
            r_erasure     <= 1'b0;
            r_range_err   <= 1'b0;
        end else if (w_accept) begin
            r_acc         <= w_acc_add;
            r_cnt         <= r_cnt + 1'b1;
            r_rerr_sticky <= r_rerr_sticky | w_sym_rerr;
            if (w_last) begin
                // Decision is taken from the sum including this final symbol.
                r_sum       <= w_acc_add;
                r_bit       <= w_acc_add[ACC_W-1];
                r_erasure   <= (w_acc_add == '0);
                r_range_err <= r_rerr_sticky | w_sym_rerr;
            end
        end else if (w_release) begin
            r_acc         <= '0;
            r_cnt         <= '0;
            r_rerr_sticky <= 1'b0;
        end
    end

    assign o_bit       = r_bit;
    assign o_sum       = r_sum;
    assign o_erasure   = r_erasure;
    assign o_range_err = r_range_err;

endmodule

// File: tb/tb_bpsk_cyc_demod.sv
module tb_bpsk_cyc_demod;

    logic              clk = 1'b0;
    logic              i_rst;
    logic              i_flush;
    logic              i_valid;
    logic [4:0]        i_cyc_part;
    logic              o_ready;
    logic              o_valid;
    logic              i_ready;
    logic              o_bit;
    logic signed [7:0] o_sum;
    logic              o_erasure;
    logic              o_range_err;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    bpsk_cyc_demod #(
        .CYC_DIV (24),
        .N_SYM   (7),
        .ACC_W   (8)
    ) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_flush     (i_flush),
        .i_valid     (i_valid),
        .i_cyc_part  (i_cyc_part),
        .o_ready     (o_ready),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_bit       (o_bit),
        .o_sum       (o_sum),
        .o_erasure   (o_erasure),
        .o_range_err (o_range_err)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Offer one phase in ACC; it must be accepted on the next rising edge.
    task automatic put(input logic [4:0] p);
        @(negedge clk);
        check("put_ready", int'(o_ready), 1);
        check("put_novalid", int'(o_valid), 0);
        i_valid    = 1'b1;
        i_cyc_part = p;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic check_dec(input string tag, input int sum, input int b,
                             input int era, input int rerr);
        check({tag, "_valid"}, int'(o_valid), 1);
        check({tag, "_sum"}, int'(o_sum), sum);
        check({tag, "_bit"}, int'(o_bit), b);
        check({tag, "_erasure"}, int'(o_erasure), era);
        check({tag, "_rangeerr"}, int'(o_range_err), rerr);
    endtask

    // Consume the decision: o_ready low during the handshake cycle, high after.
    task automatic take();
        @(negedge clk);
        check("take_bubble", int'(o_ready), 0);
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        i_ready = 1'b0;
        check("take_ready_back", int'(o_ready), 1);
        check("take_valid_drop", int'(o_valid), 0);
    endtask

    initial begin
        logic [4:0] wrap_seq [7];
        logic [4:0] rng_seq  [7];
        wrap_seq = '{5'd23, 5'd0, 5'd23, 5'd0, 5'd23, 5'd0, 5'd23};
        rng_seq  = '{5'd3, 5'd3, 5'd3, 5'd3, 5'd15, 5'd15, 5'd30};

        i_rst = 1'b1; i_flush = 1'b0; i_valid = 1'b0;
        i_cyc_part = '0; i_ready = 1'b0;
        #12;
        check("rst_valid", int'(o_valid), 0);
        check("rst_ready", int'(o_ready), 1);
        check("rst_sum", int'(o_sum), 0);
        check("rst_bit", int'(o_bit), 0);
        check("rst_erasure", int'(o_erasure), 0);
        check("rst_rangeerr", int'(o_range_err), 0);
        @(negedge clk);
        i_rst = 1'b0;

        // All bit-0 phases: 7 * 12
        for (int i = 0; i < 7; i++) put(5'd3);
        check_dec("p0", 84, 0, 0, 0);
        take();

        // All bit-1 phases, then backpressure with symbols offered in DONE
        for (int i = 0; i < 7; i++) put(5'd15);
        check_dec("p1", -84, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            i_valid    = 1'b1;
            i_cyc_part = 5'd3;
            check("bp_valid", int'(o_valid), 1);
            check("bp_ready", int'(o_ready), 0);
            check("bp_sum", int'(o_sum), -84);
            check("bp_bit", int'(o_bit), 1);
        end
        i_valid = 1'b0;
        take();

        // Wrap-around: 23 -> +4, 0 -> +6
        for (int i = 0; i < 7; i++) put(wrap_seq[i]);
        check_dec("wrap", 34, 0, 0, 0);
        take();

        // Equidistant phase -> erasure
        for (int i = 0; i < 7; i++) put(5'd9);
        check_dec("equi", 0, 0, 1, 0);
        take();

        // Out-of-range index contributes 0 and flags the block
        for (int i = 0; i < 7; i++) put(rng_seq[i]);
        check_dec("range", 24, 0, 0, 1);
        take();
        for (int i = 0; i < 7; i++) put(5'd15);
        check_dec("range_next", -84, 1, 0, 0);
        take();

        // Asynchronous reset mid-block discards the partial sum
        for (int i = 0; i < 4; i++) put(5'd3);
        @(negedge clk);
        #2;
        i_rst = 1'b1;
        #1;
        check("arst_valid", int'(o_valid), 0);
        check("arst_ready", int'(o_ready), 1);
        check("arst_sum", int'(o_sum), 0);
        check("arst_bit", int'(o_bit), 0);
        check("arst_erasure", int'(o_erasure), 0);
        check("arst_rangeerr", int'(o_range_err), 0);
        #3;
        i_rst = 1'b0;
        for (int i = 0; i < 7; i++) put(5'd15);
        check_dec("after_rst", -84, 1, 0, 0);
        take();

        // Flush with a coincident valid symbol: symbol dropped, count restarts
        for (int i = 0; i < 3; i++) put(5'd3);
        @(negedge clk);
        i_valid    = 1'b1;
        i_cyc_part = 5'd3;
        i_flush    = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_flush = 1'b0;
        check("flush_valid", int'(o_valid), 0);
        for (int i = 0; i < 6; i++) put(5'd15);
        check("flush_six_novalid", int'(o_valid), 0);
        put(5'd15);
        check_dec("flush", -84, 1, 0, 0);
        take();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bpsk_cyc_demod.md
# bpsk_cyc_demod

Receive-side BPSK demapper for the PUCCH path. It takes a stream of received cyclic phase indices on the same CYC_DIV grid that the transmit mapper uses (bit 0 → P0, bit 1 → P1). It combines N_SYM repeated symbols into one soft metric and issues a single hard bit decision per block. An erasure flag is raised when the decision is ambiguous. It sits between the phase estimator and the UCI bit sink.

## Interface
- CYC_DIV, 24: phase grid size; indices 0..CYC_DIV-1.
- N_SYM, 7: symbols combined per decision (≥1).
- ACC_W, 8: signed accumulator width; must satisfy 2^(ACC_W-1) > N_SYM·CYC_DIV/2.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset; asynchronous, active-high.
- i_flush  in  1  synchronous block abort.
- i_valid  in  1  input phase valid.
- i_cyc_part  in  5  received phase index.
- o_ready  out  1  demod accepts a phase this cycle.
- o_valid  out  1  decision valid.
- i_ready  in  1  sink accepts the decision.
- o_bit  out  1  hard decision.
- o_sum  out  ACC_W  signed combined metric.
- o_erasure  out  1  metric was exactly zero.
- o_range_err  out  1  at least one index in the block was ≥ CYC_DIV.

## Operation
- Constellation points: P0 = CYC_DIV/4 − CYC_DIV/8 and P1 = 3·CYC_DIV/4 − CYC_DIV/8, computed with integer division. With the default CYC_DIV, P0 = 3 and P1 = 15.
- Circular distance: d(x,p) = min(|x−p|, CYC_DIV−|x−p|), range 0..CYC_DIV/2.
- Per-symbol metric: m = d(x,P1) − d(x,P0), signed, range ±CYC_DIV/2. A positive metric favours bit 0.
- An index ≥ CYC_DIV contributes m = 0 and sets the sticky range-error flag for the current block.
- A symbol is accepted on i_valid && o_ready. On acceptance, acc += m and cnt++.
- FSM states:
  - ACC: o_ready=1. When the N_SYM-th symbol is accepted, latch the decision outputs and go to DONE.
  - DONE: o_valid=1 and o_ready=0. On i_ready, clear acc, cnt and the sticky flag, then go to ACC.
- Decision: sum > 0 → o_bit=0. sum < 0 → o_bit=1. sum == 0 → o_bit=0 and o_erasure=1.
- i_flush, in either state: clear acc, cnt, all flags and o_valid, go to ACC. Any symbol offered in the same cycle is dropped. Flush has priority over acceptance and over i_ready.
- In ACC, o_bit/o_sum/o_erasure/o_range_err keep their last latched values; they are meaningful only while o_valid=1.

## Timing
- Reset values: state=ACC, acc=0, cnt=0, o_ready=1, o_valid=0, o_bit=0, o_sum=0, o_erasure=0, o_range_err=0.
- Latency: o_valid rises the cycle after the N_SYM-th symbol is accepted.
- Outputs are registered and stay stable while o_valid && !i_ready, for unlimited backpressure.
- One bubble per block: in the cycle of the DONE→ACC transition, o_ready=0. o_ready returns high the next cycle.
- If reset is asserted mid-block, the partial sum is discarded. The first symbol after reset starts a new block.
- Accumulator: no saturation is needed under the ACC_W rule. The per-symbol metric is sign-extended to ACC_W before the add.

## Structure
- Package pucch_bpsk_pkg holds:
  - functions returning P0/P1 for a given CYC_DIV, shared with the transmit mapper;
  - the circular-distance function;
  - the state enum {ACC, DONE}.
- Sub-module bpsk_phase_metric: purely combinational mapping from index to (signed metric, range error).
- The top level holds the FSM, counter, accumulator and output registers.

## Test plan
- Seven phases of 3, i_ready=1 → o_valid one cycle after the 7th accept, o_sum=+84, o_bit=0, o_erasure=0.
- Seven phases of 15 → o_sum=−84, o_bit=1.
- Wrap-around:
  - Phases {23,0,23,0,23,0,23} → metrics +4 and +6, o_sum=34, o_bit=0.
  - Seven phases of 9 (equidistant) → o_sum=0, o_bit=0, o_erasure=1.
- Four phases of 3, two of 15, then 30 → o_sum=+24, o_bit=0, o_range_err=1. The next block starts with o_range_err cleared.
- Backpressure: i_ready held low for 5 cycles after o_valid → outputs constant, o_ready=0 throughout. After i_ready is raised, o_ready returns one cycle later.
- Asynchronous i_rst after 4 symbols:
  - all outputs return to reset values immediately;
  - the next 7 phases of 15 give o_sum=−84.
  - Separately, i_flush coinciding with a valid symbol → that symbol is dropped and the block count restarts at 0.
